// File: rtl/fetch_buffer.sv
// fetch_buffer: sequential instruction prefetch FIFO with redirect flush.
// Optional same-cycle response bypass to decode: FETCH_BUFFER_BYPASS_EN. Rev 1.0
`default_nettype none

module fetch_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  input  logic        instr_ready
);

  localparam int unsigned c_ptr_w = $clog2(DEPTH);
  localparam int unsigned c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_mem_valid;
  logic [31:0]          r_mem_addr;
  logic [31:0]          r_fetch_pc;
  logic [c_cnt_w-1:0]   r_count;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [31:0]          r_instr_mem [DEPTH];
  logic [31:0]          r_pc_mem    [DEPTH];

  logic                 w_nonempty;
  logic                 w_byp;
  logic                 w_byp_take;
  logic                 w_push;
  logic                 w_pop;
  logic [c_cnt_w-1:0]   w_count_nxt;
  logic [31:0]          w_pc_nxt;
  logic                 w_space;
  logic                 w_unused;

  assign w_unused   = ^redirect_pc[1:0];
  assign w_nonempty = (r_count != '0);

`ifdef FETCH_BUFFER_BYPASS_EN
  assign w_byp = !w_nonempty && (r_state == S_REQ) && mem_ready && !redirect;
`else
  assign w_byp = 1'b0;
`endif

  assign w_byp_take  = w_byp && instr_ready;
  assign w_push      = (r_state == S_REQ) && mem_ready && !redirect && !w_byp_take;
  assign w_pop       = w_nonempty && instr_ready && !redirect;
  assign w_count_nxt = redirect ? '0
                     : r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
  // A completed non-stale fetch advances the PC even when the word was consumed via bypass.
  assign w_pc_nxt    = redirect ? {redirect_pc[31:2], 2'b00}
                     : ((r_state == S_REQ) && mem_ready) ? r_fetch_pc + 32'd4
                     : r_fetch_pc;
  assign w_space     = (w_count_nxt < c_depth);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= RESET_PC;
      r_fetch_pc  <= RESET_PC;
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
    end else begin
      r_fetch_pc <= w_pc_nxt;
      r_count    <= w_count_nxt;
      if (w_push) begin
        r_instr_mem[r_wr_ptr] <= mem_rdata;
        r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
      end
      if (redirect) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      // Address is captured only when a request is launched, so it holds while draining.
      if ((r_state == S_IDLE) || mem_ready) begin
        if (w_space) begin
          r_state     <= S_REQ;
          r_mem_valid <= 1'b1;
          r_mem_addr  <= w_pc_nxt;
        end else begin
          r_state     <= S_IDLE;
          r_mem_valid <= 1'b0;
        end
      end else if ((r_state == S_REQ) && redirect) begin
        r_state <= S_DRAIN;
      end
    end
  end

  assign mem_valid = r_mem_valid;
  assign mem_instr = 1'b1;
  assign mem_addr  = r_mem_addr;

  always_comb begin
    instr_valid = 1'b0;
    instr       = NOP_INSTR;
    pc          = '0;
    if (w_nonempty) begin
      instr_valid = 1'b1;
      instr       = r_instr_mem[r_rd_ptr];
      pc          = r_pc_mem[r_rd_ptr];
    end else if (w_byp) begin
      instr_valid = 1'b1;
      instr       = mem_rdata;
      pc          = r_fetch_pc;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed and randomized checks of fetch_buffer against a queue-based model.
// Follows FETCH_BUFFER_BYPASS_EN the same way as the design. Rev 1.0
`default_nettype none

module tb_fetch_buffer;

  localparam int unsigned DEPTH     = 4;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_ready = 1'b0;

  fetch_buffer #(
    .DEPTH     (DEPTH),
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .mem_valid   (mem_valid),
    .mem_instr   (mem_instr),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .instr_ready (instr_ready)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Model: queued words, next fetch PC, whether a request is open and whether it is stale.
  logic [31:0] q_i [$];
  logic [31:0] q_p [$];
  logic [31:0] m_fpc   = RESET_PC;
  logic [31:0] m_addr  = RESET_PC;
  bit          m_act   = 1'b0;
  bit          m_stale = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input bit rstn, input bit rdy, input bit ir, input bit rd,
                      input logic [31:0] rpc, input bit rnd);
    bit          done;
    bit          byp;
    logic [31:0] rdat;
    rdat        = rnd ? 32'($urandom) : (m_addr ^ 32'hA5A5_0000);
    reset       = rstn;
    mem_ready   = rdy && m_act;
    mem_rdata   = rdat;
    instr_ready = ir;
    redirect    = rd;
    redirect_pc = rpc;
    done        = m_act && rdy;
    byp         = 1'b0;
`ifdef FETCH_BUFFER_BYPASS_EN
    byp = (q_i.size() == 0) && done && !m_stale && !rd;
`endif
    #1;
    chk("mem_valid", {31'b0, mem_valid}, {31'b0, m_act});
    chk("mem_instr", {31'b0, mem_instr}, 32'd1);
    if (m_act) chk("mem_addr", mem_addr, m_addr);
    if (q_i.size() > 0) begin
      chk("instr_valid", {31'b0, instr_valid}, 32'd1);
      chk("instr", instr, q_i[0]);
      chk("pc", pc, q_p[0]);
    end else if (byp) begin
      chk("byp_valid", {31'b0, instr_valid}, 32'd1);
      chk("byp_instr", instr, rdat);
      chk("byp_pc", pc, m_addr);
    end else begin
      chk("empty_valid", {31'b0, instr_valid}, 32'd0);
      chk("empty_instr", instr, NOP_INSTR);
      chk("empty_pc", pc, 32'd0);
    end
    @(posedge clock);
    #1;
    if (!rstn) begin
      q_i.delete(); q_p.delete();
      m_fpc = RESET_PC; m_addr = RESET_PC; m_act = 1'b0; m_stale = 1'b0;
    end else if (rd) begin
      q_i.delete(); q_p.delete();
      m_fpc = {rpc[31:2], 2'b00};
      if (m_act && !rdy) begin
        m_stale = 1'b1;
      end else begin
        m_stale = 1'b0; m_act = 1'b1; m_addr = m_fpc;
      end
    end else begin
      if (q_i.size() > 0 && ir) begin
        void'(q_i.pop_front()); void'(q_p.pop_front());
      end
      if (done) begin
        if (!m_stale) begin
          if (!(byp && ir)) begin
            q_i.push_back(rdat); q_p.push_back(m_addr);
          end
          m_fpc = m_fpc + 32'd4;
        end
        m_stale = 1'b0;
        m_act   = 1'b0;
      end
      if (!m_act && q_i.size() < DEPTH) begin
        m_act = 1'b1; m_addr = m_fpc;
      end
    end
  endtask

  initial begin
    @(posedge clock);
    #1;
    // Reset state
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, NOP_INSTR);
    chk("rst_pc", pc, 32'd0);

    // Zero-wait streaming with decode always ready
    for (int i = 0; i < 12; i++) step(1, 1, 1, 0, 0, 0);

    // Fill to DEPTH with decode stalled, then one pop
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0, 0);
    chk("full_idle", {31'b0, mem_valid}, 32'd0);
    chk("full_head_pc", pc, 32'd0);
    step(1, 0, 1, 0, 0, 0);
    chk("refill_valid", {31'b0, mem_valid}, 32'd1);
    chk("refill_addr", mem_addr, 32'd16);
    for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 0, 0);

    // Redirect while a waited request is outstanding
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 32'h0000_0103, 0);
    chk("drain_addr_hold", mem_addr, 32'd0);
    step(1, 1, 0, 0, 0, 0);
    chk("restart_addr", mem_addr, 32'h0000_0100);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0, 0);

    // Redirect coinciding with mem_ready and instr_ready, two words queued
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8 && q_i.size() < 2; i++) step(1, 1, 0, 0, 0, 0);
    chk("two_queued", {31'b0, instr_valid}, 32'd1);
    step(1, 1, 1, 1, 32'h0000_0200, 0);
    chk("flush_valid", {31'b0, instr_valid}, 32'd0);
    chk("flush_instr", instr, NOP_INSTR);
    chk("flush_addr", mem_addr, 32'h0000_0200);

    // PC wrap at the top of the address space
    step(1, 1, 1, 1, 32'hFFFF_FFFC, 0);
    chk("wrap_start", mem_addr, 32'hFFFF_FFFC);
    step(1, 1, 1, 0, 0, 0);
    chk("wrap_addr", mem_addr, 32'd0);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0, 0);

    // Reset abandons an outstanding request
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_abandon", {31'b0, mem_valid}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0),
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 29) == 0,
           32'($urandom),
           1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction prefetch queue directly upstream of the decoder.
- Issues sequential word fetches on the instruction memory port and stores returned words with their PCs in a FIFO.
- Presents the FIFO head (instr, pc) to decode with a valid/ready handshake.
- Redirect (branch/jump/trap/mret) flushes the queue, discards any stale in-flight fetch, and restarts at the target PC.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- RESET_PC, 32'h00000000, first fetch address after reset.
- NOP_INSTR, 32'h00000013, value driven on `instr` when the queue is empty.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- mem_valid  out  1  fetch request
- mem_instr  out  1  constant 1; marks the access as an instruction fetch
- mem_addr  out  32  fetch address, word aligned
- mem_rdata  in  32  fetch data; valid in the cycle mem_ready=1
- mem_ready  in  1  request complete
- redirect  in  1  flush and restart fetch
- redirect_pc  in  32  restart address; bits [1:0] ignored
- instr_valid  out  1  head entry valid
- instr  out  32  head instruction, or NOP_INSTR when empty
- pc  out  32  head PC; 0 when empty
- instr_ready  in  1  decode consumes head this cycle

Behaviour:
- Reset (reset=0 at a rising edge):
  - count=0, rd/wr pointers=0, fetch_pc=RESET_PC, state=IDLE.
  - mem_valid=0, instr_valid=0, instr=NOP_INSTR, pc=0.
- Memory protocol:
  - Once mem_valid=1, mem_valid and mem_addr hold stable until the cycle mem_ready=1.
  - At most one request outstanding.
  - Zero-wait responses (ready in the same cycle as valid) are supported.
- State machine:
  - IDLE: go to REQ when count < DEPTH (space is reserved for the outstanding word).
  - REQ: mem_valid=1, mem_addr=fetch_pc.
    - On mem_ready with no redirect: write {mem_rdata, fetch_pc} to the FIFO and set fetch_pc += 4 (wraps modulo 2^32).
    - Then go to REQ if there is still space, else IDLE.
  - DRAIN: stale request still outstanding. mem_valid stays 1 with the old address. On mem_ready the data is dropped; go to REQ at the new fetch_pc.
- Pop: when instr_valid && instr_ready, advance rd pointer. A push and a pop in the same cycle leave count unchanged.
- Full:
  - No new request is issued while count == DEPTH.
  - A pop in the same cycle frees space, but the request starts next cycle.
- Empty: instr_valid=0, instr=NOP_INSTR; instr_ready is ignored.
- Redirect, when redirect=1 at a clock edge:
  - count and pointers are cleared and fetch_pc = {redirect_pc[31:2], 2'b00}.
  - Any pop that cycle is void.
  - If a request is outstanding and mem_ready=0: go to DRAIN.
  - If mem_ready=1 that same cycle: drop the data and go to REQ at the new PC.
  - From IDLE: go to REQ.
  - Redirect during DRAIN: update fetch_pc only and stay in DRAIN.
- Latency: redirect at edge N gives mem_valid at the new address in cycle N+1. With zero-wait memory, instr_valid rises in cycle N+2 (N+1 with bypass; see below).
- Reset mid-request: the outstanding request is abandoned; mem_valid=0 the next cycle. The memory must tolerate this.
- Outputs instr_valid/instr/pc come from FIFO registers and pointer state (no combinational path from mem_rdata) unless bypass is enabled.

Optional Feature:
- Macro FETCH_BUFFER_BYPASS_EN.
- Defined:
  - When the FIFO is empty, mem_ready=1, not in DRAIN and redirect=0, mem_rdata and fetch_pc drive instr/pc directly with instr_valid=1.
  - If instr_ready=1 that cycle, the word is consumed and not written.
  - Saves one cycle of fetch-to-decode latency.
- Undefined: every word passes through the FIFO; minimum response-to-decode latency is one cycle.

Test Plan:
- Reset release, zero-wait memory returning mem_rdata=addr^32'hA5A50000, instr_ready=1 -> mem_addr sequence 0,4,8,...; decode sees pc=0,4,8 with matching instr; instr_valid stays high continuously after the first word.
- instr_ready=0 held, DEPTH=4 -> exactly 4 requests complete; mem_valid=0 with count=4. Raise instr_ready for one cycle -> one pop, one new request to addr 16 the next cycle.
- Memory with 3-cycle wait, redirect to 32'h00000103 in wait cycle 2 -> mem_addr holds the old value until mem_ready; that word is not enqueued; the next request is to 0x100; first decoded pc=0x100.
- Redirect in the same cycle as mem_ready and instr_ready, queue holding 2 entries -> queue empty next cycle (instr=0x13, instr_valid=0); returned word dropped; fetch restarts at the target.
- fetch_pc=32'hFFFFFFFC -> next request address 0, no stall.
- Bypass build, empty queue, zero-wait memory -> instr_valid=1 in the response cycle with instr=mem_rdata; count stays 0. Non-bypass build -> instr_valid rises one cycle later.
